// File: rtl/shake_squeeze_reader_pkg.sv
// Shared SHAKE constants and types: rate widths (also used by the absorb
// controller), mode encoding, squeeze FSM states and byte-trim helpers.
package shake_pkg;

    localparam int unsigned SHAKE128_RATE_W = 42;
    localparam int unsigned SHAKE256_RATE_W = 34;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_e;

    typedef enum logic [2:0] {
        SQZ_IDLE,
        SQZ_WAIT_PERM,
        SQZ_PRIME,
        SQZ_STREAM,
        SQZ_NEXT,
        SQZ_DONE
    } sqz_state_e;

    // Index of the final rate word for the selected mode.
    function automatic logic [5:0] rate_last(input shake_mode_e m);
        return (m == SHAKE256) ? 6'(SHAKE256_RATE_W - 1) : 6'(SHAKE128_RATE_W - 1);
    endfunction

    // Byte-enable for the final word; 0 means a full 4-byte word.
    function automatic logic [3:0] trim_keep(input logic [1:0] lb);
        logic [3:0] k;
        k = 4'hF;
        case (lb)
            2'd1:    k = 4'h1;
            2'd2:    k = 4'h3;
            2'd3:    k = 4'h7;
            default: k = 4'hF;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] keep_bits(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

endpackage

// File: rtl/shake_squeeze_reader_if.sv
// Bus bundle for the squeeze reader: control, sha3 core read port and the
// output valid/ready stream. Optional SHAKE_SQZ_BYTE_TRIM_EN adds last_bytes
// and out_keep. master = squeeze reader, slave = its environment.
interface shake_squeeze_reader_if
    import shake_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    shake_mode_e       mode;
    logic [CNT_W-1:0]  out_words;
    logic              core_ready;
    logic [DATA_W-1:0] core_dout;
    logic [5:0]        core_addr;
    logic              core_next;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [CNT_W-1:0]  out_idx;
    logic              busy;
    logic              done;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
    logic [1:0]        last_bytes;
    logic [3:0]        out_keep;

    modport master (
        input  start, mode, out_words, last_bytes, core_ready, core_dout, out_ready,
        output core_addr, core_next, out_data, out_valid, out_last, out_idx, busy, done,
               out_keep
    );
    modport slave (
        output start, mode, out_words, last_bytes, core_ready, core_dout, out_ready,
        input  core_addr, core_next, out_data, out_valid, out_last, out_idx, busy, done,
               out_keep
    );
`else
    modport master (
        input  start, mode, out_words, core_ready, core_dout, out_ready,
        output core_addr, core_next, out_data, out_valid, out_last, out_idx, busy, done
    );
    modport slave (
        output start, mode, out_words, core_ready, core_dout, out_ready,
        input  core_addr, core_next, out_data, out_valid, out_last, out_idx, busy, done
    );
`endif
endinterface

// File: rtl/shake_squeeze_reader.sv
// SHAKE squeeze reader: reads rate words out of the sha3 core state and
// streams them over valid/ready, requesting further permutations via
// core_next when the output spans several rate blocks.
// Optional: define SHAKE_SQZ_BYTE_TRIM_EN for last_bytes/out_keep trimming.
// DATA_W is fixed at 32.
module shake_squeeze_reader
    import shake_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shake_squeeze_reader_if.master sqz_io
);

    sqz_state_e        state_q, state_d;
    shake_mode_e       mode_q, mode_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  cap_q, cap_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [5:0]        addr_q, addr_d;
    logic              blk_end_q, blk_end_d;
    logic              skip_q, skip_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
    logic [1:0]        lb_q, lb_d;
    logic [3:0]        keep_q, keep_d;
`endif

    logic       fire;
    logic       cap_en;
    logic       cap_last;
    logic [5:0] rate_m1;

    assign rate_m1  = rate_last(mode_q);
    assign fire     = valid_q & sqz_io.out_ready;
    assign cap_last = (cap_q == (words_q - CNT_W'(1)));

    // State and datapath registers; async reset aborts any stream in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SQZ_IDLE;
            mode_q    <= SHAKE128;
            words_q   <= '0;
            cap_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            blk_end_q <= 1'b0;
            skip_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
            lb_q      <= '0;
            keep_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            words_q   <= words_d;
            cap_q     <= cap_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            blk_end_q <= blk_end_d;
            skip_q    <= skip_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
            lb_q      <= lb_d;
            keep_q    <= keep_d;
`endif
        end
    end

    // Next-state, capture and core-address logic.
    // addr_q is the address whose word is on core_dout now; core_addr
    // presents addr_d, which only advances on a capture, so a stall keeps
    // the address and therefore core_dout unchanged.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        words_d   = words_q;
        cap_d     = cap_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        blk_end_d = blk_end_q;
        skip_d    = skip_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cap_en    = 1'b0;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
        lb_d      = lb_q;
        keep_d    = keep_q;
`endif
        case (state_q)
            SQZ_IDLE: begin
                if (sqz_io.start) begin
                    mode_d    = sqz_io.mode;
                    words_d   = sqz_io.out_words;
                    busy_d    = 1'b1;
                    cap_d     = '0;
                    idx_d     = '0;
                    addr_d    = '0;
                    blk_end_d = 1'b0;
                    skip_d    = 1'b0;
                    last_d    = 1'b0;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
                    lb_d      = sqz_io.last_bytes;
`endif
                    state_d   = (sqz_io.out_words == '0) ? SQZ_DONE : SQZ_WAIT_PERM;
                end
            end
            SQZ_WAIT_PERM: begin
                // The core lowers ready one cycle after core_next, so the
                // first cycle after NEXT must not trust core_ready.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (sqz_io.core_ready) begin
                    addr_d    = '0;
                    blk_end_d = 1'b0;
                    state_d   = SQZ_PRIME;
                end
            end
            SQZ_PRIME: begin
                state_d = SQZ_STREAM;
            end
            SQZ_STREAM: begin
                cap_en = (!valid_q || sqz_io.out_ready) && !blk_end_q && (cap_q != words_q);
                if (fire) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = SQZ_DONE;
                    end else if (blk_end_q) begin
                        state_d = SQZ_NEXT;
                    end
                end
                if (cap_en) begin
                    valid_d   = 1'b1;
                    idx_d     = cap_q;
                    cap_d     = cap_q + CNT_W'(1);
                    last_d    = cap_last;
                    blk_end_d = (addr_q == rate_m1);
                    if (addr_q != rate_m1) begin
                        addr_d = addr_q + 6'd1;
                    end
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
                    keep_d = cap_last ? trim_keep(lb_q) : 4'hF;
                    data_d = sqz_io.core_dout & DATA_W'(keep_bits(keep_d));
`else
                    data_d = sqz_io.core_dout;
`endif
                end
            end
            SQZ_NEXT: begin
                skip_d  = 1'b1;
                state_d = SQZ_WAIT_PERM;
            end
            SQZ_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = SQZ_IDLE;
            end
            default: begin
                state_d = SQZ_IDLE;
            end
        endcase
    end

    assign sqz_io.core_addr = addr_d;
    assign sqz_io.core_next = (state_q == SQZ_NEXT);
    assign sqz_io.out_data  = data_q;
    assign sqz_io.out_valid = valid_q;
    assign sqz_io.out_last  = last_q;
    assign sqz_io.out_idx   = idx_q;
    assign sqz_io.busy      = busy_q;
    assign sqz_io.done      = done_q;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
    assign sqz_io.out_keep  = keep_q;
`endif

endmodule

// File: tb/tb_shake_squeeze_reader.sv
// Directed bench for shake_squeeze_reader with a behavioural sha3 core:
// state words are a known function of (permutation number, word index) and
// read back garbage while a permutation is in progress.
module tb_shake_squeeze_reader;
    import shake_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    shake_squeeze_reader_if #(.CNT_W(16), .DATA_W(32)) bus ();

    shake_squeeze_reader #(.CNT_W(16), .DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sqz_io (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- core model ----------------
    int unsigned perm  = 0;
    int unsigned pbusy = 0;

    function automatic logic [31:0] core_word(input int unsigned p, input int unsigned a);
        logic [7:0] pb;
        logic [7:0] ab;
        pb = 8'(p);
        ab = 8'(a);
        return {8'h5A, pb, ab, ab ^ 8'h3C};
    endfunction

    // Ready is updated from the old busy count, so it drops one cycle late.
    always @(posedge clk) begin
        if (pbusy != 0) bus.core_dout <= 32'hDEAD_0000 | 32'(bus.core_addr);
        else            bus.core_dout <= core_word(perm, 32'(bus.core_addr));
        if (bus.core_next) begin
            pbusy <= 5;
        end else if (pbusy != 0) begin
            pbusy <= pbusy - 1;
            if (pbusy == 1) perm <= perm + 1;
        end
        bus.core_ready <= (pbusy == 0);
    end

    // ---------------- consumer ready ----------------
    bit rand_ready = 1'b0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    bit          mon_en     = 1'b0;
    int unsigned case_words = 0;
    int unsigned case_rate  = 42;
    int unsigned case_base  = 0;
    logic [1:0]  case_lb    = 2'd0;
    int unsigned rx_base    = 0;

    int unsigned rx_tot   = 0;
    int unsigned vld_tot  = 0;
    int unsigned next_tot = 0;
    int unsigned done_tot = 0;
    bit          stall_q  = 1'b0;
    logic [31:0] st_data;
    logic [15:0] st_idx;
    logic        st_last;

    function automatic logic [3:0] exp_keep(input int unsigned k);
        logic [3:0] m;
        m = 4'hF;
        if (k == case_words - 1) begin
            case (case_lb)
                2'd1:    m = 4'h1;
                2'd2:    m = 4'h3;
                2'd3:    m = 4'h7;
                default: m = 4'hF;
            endcase
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_data(input int unsigned k);
        logic [3:0]  m;
        logic [31:0] w;
        m = exp_keep(k);
        w = core_word(case_base + k / case_rate, k % case_rate);
        return w & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_data", bus.out_data, st_data);
                chk("stall_idx", bus.out_idx, st_idx);
                chk("stall_last", bus.out_last, st_last);
            end
            stall_q = bus.out_valid && !bus.out_ready;
            st_data = bus.out_data;
            st_idx  = bus.out_idx;
            st_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                int unsigned k;
                k = rx_tot - rx_base;
                chk("data", bus.out_data, exp_data(k));
                chk("idx", bus.out_idx, 16'(k));
                chk("last", bus.out_last, k == case_words - 1);
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
                chk("keep", bus.out_keep, exp_keep(k));
`endif
                rx_tot++;
            end
            if (bus.out_valid) vld_tot++;
            if (bus.core_next) next_tot++;
            if (bus.done) done_tot++;
            if (bus.busy) chk("addr_range", bus.core_addr < 6'(case_rate), 1'b1);
        end
    end

    int unsigned vld_base, next_base, done_base;

    task automatic begin_case(input shake_mode_e m, input int unsigned w, input logic [1:0] lb);
        @(posedge clk);
        #1;
        case_words = w;
        case_rate  = (m == SHAKE256) ? SHAKE256_RATE_W : SHAKE128_RATE_W;
        case_base  = perm;
        case_lb    = lb;
        rx_base    = rx_tot;
        vld_base   = vld_tot;
        next_base  = next_tot;
        done_base  = done_tot;
        mon_en     = 1'b1;
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.out_words = 16'(w);
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
        bus.last_bytes = lb;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_set", bus.busy, 1'b1);
    endtask

    task automatic run_case(input shake_mode_e m, input int unsigned w, input bit rnd,
                            input bit poke, input logic [1:0] lb);
        int unsigned n;
        rand_ready = rnd;
        begin_case(m, w, lb);
        n = 0;
        while (!bus.done && n < 20000) begin
            // A second start while busy must be ignored.
            bus.start     = poke && (n == 5);
            bus.mode      = (poke && n == 5) ? SHAKE128 : m;
            bus.out_words = (poke && n == 5) ? 16'd5 : 16'(w);
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        chk("done_timeout", n < 20000, 1'b1);
        chk("busy_at_done", bus.busy, 1'b0);
        chk("valid_at_done", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("done_pulse", bus.done, 1'b0);
        chk("words", rx_tot - rx_base, w);
        chk("next_cnt", next_tot - next_base, (w == 0) ? 0 : (w - 1) / case_rate);
        chk("done_cnt", done_tot - done_base, 1);
        if (!rnd) chk("vld_cycles", vld_tot - vld_base, w);
        mon_en     = 1'b0;
        rand_ready = 1'b0;
    endtask

    task automatic zero_case();
        rand_ready = 1'b0;
        begin_case(SHAKE128, 0, 2'd0);
        chk("z_done_early", bus.done, 1'b0);
        @(posedge clk);
        #1;
        chk("z_done", bus.done, 1'b1);
        chk("z_busy_clr", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        chk("z_done_pulse", bus.done, 1'b0);
        chk("z_valid", vld_tot - vld_base, 0);
        chk("z_next", next_tot - next_base, 0);
        mon_en = 1'b0;
    endtask

    task automatic reset_case();
        int unsigned n;
        rand_ready = 1'b0;
        begin_case(SHAKE128, 42, 2'd0);
        n = 0;
        while ((rx_tot - rx_base) < 10 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("r_reach10", n < 1000, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("r_valid", bus.out_valid, 1'b0);
        chk("r_data", bus.out_data, 32'd0);
        chk("r_idx", bus.out_idx, 16'd0);
        chk("r_last", bus.out_last, 1'b0);
        chk("r_busy", bus.busy, 1'b0);
        chk("r_done", bus.done, 1'b0);
        chk("r_next", bus.core_next, 1'b0);
        chk("r_addr", bus.core_addr, 6'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("r_no_done", done_tot - done_base, 0);
        chk("r_idle_busy", bus.busy, 1'b0);
        mon_en = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.mode      = SHAKE128;
        bus.out_words = '0;
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
        bus.last_bytes = 2'd0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_idx", bus.out_idx, 16'd0);
        chk("rst_last", bus.out_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_next", bus.core_next, 1'b0);
        chk("rst_addr", bus.core_addr, 6'd0);
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
        chk("rst_keep", bus.out_keep, 4'h0);
`endif
        rst_n = 1'b1;

        run_case(SHAKE128, 42, 1'b0, 1'b0, 2'd0);
        run_case(SHAKE128, 43, 1'b0, 1'b0, 2'd0);
        run_case(SHAKE256, 70, 1'b0, 1'b0, 2'd0);
        run_case(SHAKE128, 100, 1'b1, 1'b0, 2'd0);
        run_case(SHAKE256, 100, 1'b0, 1'b1, 2'd0);
        zero_case();
        reset_case();
        run_case(SHAKE256, 35, 1'b1, 1'b0, 2'd0);
`ifdef SHAKE_SQZ_BYTE_TRIM_EN
        run_case(SHAKE128, 3, 1'b0, 1'b0, 2'd2);
        run_case(SHAKE128, 1, 1'b0, 1'b0, 2'd3);
        run_case(SHAKE256, 2, 1'b0, 1'b0, 2'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
